// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter that shares one fixed-latency BRAM read port among NREQ requesters.
// Each read that is issued pushes its requester index into a tag pipeline that is
// RD_LAT entries deep. When the read data comes back, the pipeline routes it to that
// requester.
module bram_rd_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 bram_rd_o,
    output logic [AW-1:0]        bram_addr_o,
    input  logic [DW-1:0]        bram_dout_i,
    output logic                 idle_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    // Issue-side state
    logic            bram_rd_q,   bram_rd_d;
    logic [AW-1:0]   bram_addr_q, bram_addr_d;
    logic [IdxW-1:0] win_idx_q,   win_idx_d;
    logic [IdxW-1:0] ptr_q,       ptr_d;

    // Return tag pipeline: entry RD_LAT-1 lines up with valid bram_dout
    logic [RD_LAT-1:0] tag_vld_q;
    logic [IdxW-1:0]   tag_idx_q [RD_LAT];

    // Arbitration signals
    logic [NREQ-1:0] eligible;
    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic [IdxW:0]   cand_sum;
    logic [IdxW-1:0] cand;
    logic [AW-1:0]   addr_sel;

    // Grant is a registered decode of the issued index; valid only while bram_rd is high
    always_comb begin
        gnt_o = '0;
        if (bram_rd_q) begin
            gnt_o[win_idx_q] = 1'b1;
        end
    end

    // A request granted this cycle must not win again before the requester reacts
    always_comb begin
        eligible = req_i & ~gnt_o;
    end

    // Round-robin search starting at ptr_q, wrapping modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IdxW+1)'(k);
            if (cand_sum >= (IdxW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IdxW+1)'(NREQ);
            end
            cand = cand_sum[IdxW-1:0];
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Address mux for the winning requester
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IdxW'(i)) begin
                addr_sel = addr_i[i*AW +: AW];
            end
        end
    end

    // Next issue state: bram_addr and the issued index hold when nothing wins
    always_comb begin
        bram_rd_d   = win_found;
        bram_addr_d = bram_addr_q;
        win_idx_d   = win_idx_q;
        ptr_d       = ptr_q;
        if (win_found) begin
            bram_addr_d = addr_sel;
            win_idx_d   = win_idx;
            ptr_d       = (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + IdxW'(1);
        end
    end

    // Issue registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bram_rd_q   <= 1'b0;
            bram_addr_q <= '0;
            win_idx_q   <= '0;
            ptr_q       <= '0;
        end else begin
            bram_rd_q   <= bram_rd_d;
            bram_addr_q <= bram_addr_d;
            win_idx_q   <= win_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    // Tag shift register; reset drops all in-flight reads so none return afterwards
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= bram_rd_q;
            tag_idx_q[0] <= win_idx_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    // Return routing and status outputs
    always_comb begin
        rvalid_o = '0;
        if (tag_vld_q[RD_LAT-1]) begin
            rvalid_o[tag_idx_q[RD_LAT-1]] = 1'b1;
        end
        rdata_o     = bram_dout_i;
        bram_rd_o   = bram_rd_q;
        bram_addr_o = bram_addr_q;
        idle_o      = ~bram_rd_q & ~(|tag_vld_q);
    end

endmodule
